// File: rtl/mem_stage_lsu_if.sv
// Bundle between the MEM stage LSU, the issuing pipeline and the data cache.
// The LSU takes the master modport; the pipeline/cache environment takes the slave modport.
interface mem_stage_lsu_if;
    logic        MEM_valid_a;
    logic        MEM_valid_b;
    logic [2:0]  MEM_mem_type_a;
    logic [2:0]  MEM_mem_type_b;
    logic        MEM_mem_we_a;
    logic        MEM_mem_we_b;
    logic [31:0] MEM_alu_result_a;
    logic [31:0] MEM_alu_result_b;
    logic [31:0] MEM_store_data_a;
    logic [31:0] MEM_store_data_b;

    logic        stall_dcache;
    logic [31:0] MEM_rf_wdata_a;
    logic [31:0] MEM_rf_wdata_b;
    logic        mem_ale_a;
    logic        mem_ale_b;

    logic        dc_req;
    logic        dc_we;
    logic [31:0] dc_addr;
    logic [3:0]  dc_wstrb;
    logic [31:0] dc_wdata;
    logic        dc_addr_ok;
    logic        dc_data_ok;
    logic [31:0] dc_rdata;

    modport master (
        input  MEM_valid_a, MEM_valid_b, MEM_mem_type_a, MEM_mem_type_b,
        input  MEM_mem_we_a, MEM_mem_we_b, MEM_alu_result_a, MEM_alu_result_b,
        input  MEM_store_data_a, MEM_store_data_b,
        output stall_dcache, MEM_rf_wdata_a, MEM_rf_wdata_b, mem_ale_a, mem_ale_b,
        output dc_req, dc_we, dc_addr, dc_wstrb, dc_wdata,
        input  dc_addr_ok, dc_data_ok, dc_rdata
    );

    modport slave (
        output MEM_valid_a, MEM_valid_b, MEM_mem_type_a, MEM_mem_type_b,
        output MEM_mem_we_a, MEM_mem_we_b, MEM_alu_result_a, MEM_alu_result_b,
        output MEM_store_data_a, MEM_store_data_b,
        input  stall_dcache, MEM_rf_wdata_a, MEM_rf_wdata_b, mem_ale_a, mem_ale_b,
        input  dc_req, dc_we, dc_addr, dc_wstrb, dc_wdata,
        output dc_addr_ok, dc_data_ok, dc_rdata
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// Dual-slot MEM stage load/store unit: serialises slot A then slot B onto a single
// dcache port, stalling the pipeline until every live memory op has completed.
module mem_stage_lsu (
    input  logic             clk,
    input  logic             rstn,
    mem_stage_lsu_if.master  bus
);

    localparam logic [2:0] MT_B  = 3'b001;
    localparam logic [2:0] MT_H  = 3'b010;
    localparam logic [2:0] MT_W  = 3'b011;
    localparam logic [2:0] MT_BU = 3'b101;
    localparam logic [2:0] MT_HU = 3'b110;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    function automatic logic isMemType(input logic [2:0] t);
        return (t == MT_B) || (t == MT_H) || (t == MT_W) || (t == MT_BU) || (t == MT_HU);
    endfunction

    function automatic logic isMisaligned(input logic [2:0] t, input logic [1:0] off);
        return (((t == MT_H) || (t == MT_HU)) && off[0]) || ((t == MT_W) && (off != 2'b00));
    endfunction

    function automatic logic [31:0] loadExtend(input logic [2:0] t, input logic [31:0] rdata,
                                               input logic [1:0] off);
        logic [31:0] sh;
        sh = rdata >> {off, 3'b000};
        case (t)
            MT_B:    return {{24{sh[7]}}, sh[7:0]};
            MT_BU:   return {24'd0, sh[7:0]};
            MT_H:    return {{16{sh[15]}}, sh[15:0]};
            MT_HU:   return {16'd0, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic        cur_q, cur_d;
    logic        doneA_q, doneA_d;
    logic        doneB_q, doneB_d;
    logic [31:0] loadDataA_q, loadDataA_d;
    logic [31:0] loadDataB_q, loadDataB_d;

    logic        isMemA, isMemB;
    logic        aleA, aleB;
    logic        activeA, activeB;
    logic        pendA, pendB;
    logic        stall;
    logic        dataDone;

    logic [2:0]  curType;
    logic        curWe;
    logic [31:0] curAddr;
    logic [31:0] curData;
    logic [31:0] curLoad;

    // A misaligned slot A squashes slot B as well, since B is younger.
    always_comb begin
        isMemA  = bus.MEM_valid_a && isMemType(bus.MEM_mem_type_a);
        isMemB  = bus.MEM_valid_b && isMemType(bus.MEM_mem_type_b);
        aleA    = isMemA && isMisaligned(bus.MEM_mem_type_a, bus.MEM_alu_result_a[1:0]);
        aleB    = isMemB && isMisaligned(bus.MEM_mem_type_b, bus.MEM_alu_result_b[1:0]);
        activeA = isMemA && !aleA;
        activeB = isMemB && !aleB && !aleA;
        pendA   = activeA && !doneA_q;
        pendB   = activeB && !doneB_q;
        stall   = pendA || pendB;
    end

    always_comb begin
        curType = cur_q ? bus.MEM_mem_type_b   : bus.MEM_mem_type_a;
        curWe   = cur_q ? bus.MEM_mem_we_b     : bus.MEM_mem_we_a;
        curAddr = cur_q ? bus.MEM_alu_result_b : bus.MEM_alu_result_a;
        curData = cur_q ? bus.MEM_store_data_b : bus.MEM_store_data_a;
        curLoad = loadExtend(curType, bus.dc_rdata, curAddr[1:0]);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cur_q       <= 1'b0;
            doneA_q     <= 1'b0;
            doneB_q     <= 1'b0;
            loadDataA_q <= 32'd0;
            loadDataB_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            doneA_q     <= doneA_d;
            doneB_q     <= doneB_d;
            loadDataA_q <= loadDataA_d;
            loadDataB_q <= loadDataB_d;
        end
    end

    // data_ok only counts in WAIT, so a response left over from a reset access is dropped.
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        dataDone = 1'b0;
        case (state_q)
            IDLE: begin
                if (pendA) begin
                    state_d = REQ;
                    cur_d   = 1'b0;
                end else if (pendB) begin
                    state_d = REQ;
                    cur_d   = 1'b1;
                end
            end
            REQ: begin
                if (bus.dc_addr_ok) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.dc_data_ok) begin
                    dataDone = 1'b1;
                    if (!cur_q && pendB) begin
                        state_d = REQ;
                        cur_d   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Done flags live for exactly one instruction: they drop when the pipeline advances.
    always_comb begin
        doneA_d     = doneA_q;
        doneB_d     = doneB_q;
        loadDataA_d = loadDataA_q;
        loadDataB_d = loadDataB_q;
        if (!stall) begin
            doneA_d = 1'b0;
            doneB_d = 1'b0;
        end else if (dataDone) begin
            if (cur_q) begin
                doneB_d = 1'b1;
            end else begin
                doneA_d = 1'b1;
            end
        end
        if (dataDone) begin
            if (cur_q) begin
                loadDataB_d = curLoad;
            end else begin
                loadDataA_d = curLoad;
            end
        end
    end

    always_comb begin
        bus.dc_req   = 1'b0;
        bus.dc_we    = 1'b0;
        bus.dc_addr  = 32'd0;
        bus.dc_wstrb = 4'd0;
        bus.dc_wdata = 32'd0;
        if (state_q == REQ) begin
            bus.dc_req  = 1'b1;
            bus.dc_we   = curWe;
            bus.dc_addr = {curAddr[31:2], 2'b00};
            if (curWe) begin
                case (curType)
                    MT_B, MT_BU: begin
                        bus.dc_wstrb = 4'b0001 << curAddr[1:0];
                        bus.dc_wdata = {4{curData[7:0]}};
                    end
                    MT_H, MT_HU: begin
                        bus.dc_wstrb = 4'b0011 << curAddr[1:0];
                        bus.dc_wdata = {2{curData[15:0]}};
                    end
                    default: begin
                        bus.dc_wstrb = 4'b1111;
                        bus.dc_wdata = curData;
                    end
                endcase
            end
        end
    end

    always_comb begin
        bus.stall_dcache   = stall;
        bus.mem_ale_a      = aleA;
        bus.mem_ale_b      = aleB;
        bus.MEM_rf_wdata_a = (doneA_q && !bus.MEM_mem_we_a) ? loadDataA_q : bus.MEM_alu_result_a;
        bus.MEM_rf_wdata_b = (doneB_q && !bus.MEM_mem_we_b) ? loadDataB_q : bus.MEM_alu_result_b;
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: a vector table run through a simple in-order
// dcache responder, plus hand sequences for back-pressure and mid-access reset.
module tb_mem_stage_lsu;

    typedef struct {
        logic        vA;
        logic [2:0]  tA;
        logic        weA;
        logic [31:0] addrA;
        logic [31:0] dataA;
        logic        vB;
        logic [2:0]  tB;
        logic        weB;
        logic [31:0] addrB;
        logic [31:0] dataB;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic        eAleA;
        logic        eAleB;
        int          eNreq;
        logic        eWe0;
        logic [31:0] eAddr0;
        logic [3:0]  eWstrb0;
        logic [31:0] eWdata0;
        logic [31:0] eAddr1;
        logic [31:0] eRfA;
        logic [31:0] eRfB;
    } vec_t;

    localparam int NUM_VEC = 13;

    logic clk;
    logic rstn;
    int   testsRun;
    int   testsFailed;
    vec_t vecs[NUM_VEC];

    mem_stage_lsu_if bus();

    mem_stage_lsu dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic setSlots(input logic vA, input logic [2:0] tA, input logic weA,
                            input logic [31:0] addrA, input logic [31:0] dataA,
                            input logic vB, input logic [2:0] tB, input logic weB,
                            input logic [31:0] addrB, input logic [31:0] dataB);
        bus.MEM_valid_a      = vA;
        bus.MEM_mem_type_a   = tA;
        bus.MEM_mem_we_a     = weA;
        bus.MEM_alu_result_a = addrA;
        bus.MEM_store_data_a = dataA;
        bus.MEM_valid_b      = vB;
        bus.MEM_mem_type_b   = tB;
        bus.MEM_mem_we_b     = weB;
        bus.MEM_alu_result_b = addrB;
        bus.MEM_store_data_b = dataB;
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        int          cycles;
        int          nreq;
        logic        waitData;
        logic        reqWe[2];
        logic [31:0] reqAddr[2];
        logic [3:0]  reqWstrb[2];
        logic [31:0] reqWdata[2];
        int          expCycles;

        setSlots(v.vA, v.tA, v.weA, v.addrA, v.dataA, v.vB, v.tB, v.weB, v.addrB, v.dataB);
        bus.dc_addr_ok = 1'b0;
        bus.dc_data_ok = 1'b0;
        #1;
        checkOutput($sformatf("v%0d_aleA", idx), {31'd0, bus.mem_ale_a}, {31'd0, v.eAleA});
        checkOutput($sformatf("v%0d_aleB", idx), {31'd0, bus.mem_ale_b}, {31'd0, v.eAleB});

        cycles   = 0;
        nreq     = 0;
        waitData = 1'b0;
        for (int k = 0; k < 2; k++) begin
            reqWe[k] = 1'b0; reqAddr[k] = 32'd0; reqWstrb[k] = 4'd0; reqWdata[k] = 32'd0;
        end
        while (bus.stall_dcache && cycles < 30) begin
            bus.dc_addr_ok = 1'b0;
            bus.dc_data_ok = 1'b0;
            if (waitData) begin
                bus.dc_data_ok = 1'b1;
                bus.dc_rdata   = (nreq == 1) ? v.rd0 : v.rd1;
                waitData       = 1'b0;
            end else if (bus.dc_req) begin
                if (nreq < 2) begin
                    reqWe[nreq]    = bus.dc_we;
                    reqAddr[nreq]  = bus.dc_addr;
                    reqWstrb[nreq] = bus.dc_wstrb;
                    reqWdata[nreq] = bus.dc_wdata;
                end
                bus.dc_addr_ok = 1'b1;
                waitData       = 1'b1;
                nreq++;
            end
            tick();
            cycles++;
        end
        bus.dc_addr_ok = 1'b0;
        bus.dc_data_ok = 1'b0;

        expCycles = (v.eNreq == 0) ? 0 : 1 + 2 * v.eNreq;
        checkOutput($sformatf("v%0d_stallEnd", idx), {31'd0, bus.stall_dcache}, 32'd0);
        checkOutput($sformatf("v%0d_stallCycles", idx), cycles, expCycles);
        checkOutput($sformatf("v%0d_nreq", idx), nreq, v.eNreq);
        if (v.eNreq > 0) begin
            checkOutput($sformatf("v%0d_we0", idx), {31'd0, reqWe[0]}, {31'd0, v.eWe0});
            checkOutput($sformatf("v%0d_addr0", idx), reqAddr[0], v.eAddr0);
            checkOutput($sformatf("v%0d_wstrb0", idx), {28'd0, reqWstrb[0]}, {28'd0, v.eWstrb0});
            if (v.eWe0) begin
                checkOutput($sformatf("v%0d_wdata0", idx), reqWdata[0], v.eWdata0);
            end
        end
        if (v.eNreq > 1) begin
            checkOutput($sformatf("v%0d_addr1", idx), reqAddr[1], v.eAddr1);
        end
        checkOutput($sformatf("v%0d_rfA", idx), bus.MEM_rf_wdata_a, v.eRfA);
        checkOutput($sformatf("v%0d_rfB", idx), bus.MEM_rf_wdata_b, v.eRfB);
        tick();
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;

        //           vA tA     weA addrA         dataA         vB tB     weB addrB         dataB         rd0           rd1           aA  aB  n  we0 addr0         wstrb0   wdata0        addr1         rfA           rfB
        vecs[0]  = '{1, 3'b001, 0, 32'h0000_1003, 32'h0,        1, 3'b000, 0, 32'h0000_0055, 32'h0,        32'h8000_0000, 32'h0,        0, 0, 1, 0, 32'h0000_1000, 4'b0000, 32'h0,        32'h0,        32'hFFFF_FF80, 32'h0000_0055};
        vecs[1]  = '{1, 3'b000, 0, 32'h0000_0007, 32'h0,        1, 3'b010, 1, 32'h0000_2002, 32'h1234_ABCD, 32'h0,        32'h0,        0, 0, 1, 1, 32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 32'h0,        32'h0000_0007, 32'h0000_2002};
        vecs[2]  = '{1, 3'b011, 0, 32'h0000_0100, 32'h0,        1, 3'b110, 0, 32'h0000_0106, 32'h0,        32'h1122_3344, 32'hBEEF_0000, 0, 0, 2, 0, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000_0104, 32'h1122_3344, 32'h0000_BEEF};
        vecs[3]  = '{1, 3'b011, 0, 32'h0000_0101, 32'h0,        1, 3'b011, 1, 32'h0000_0200, 32'h12,       32'h0,        32'h0,        1, 0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        32'h0000_0101, 32'h0000_0200};
        vecs[4]  = '{1, 3'b001, 1, 32'h0000_0301, 32'h0000_00A5, 1, 3'b000, 0, 32'h0000_0009, 32'h0,        32'h0,        32'h0,        0, 0, 1, 1, 32'h0000_0300, 4'b0010, 32'hA5A5_A5A5, 32'h0,        32'h0000_0301, 32'h0000_0009};
        vecs[5]  = '{1, 3'b101, 0, 32'h0000_0402, 32'h0,        1, 3'b000, 0, 32'h0000_0000, 32'h0,        32'h00F1_0000, 32'h0,        0, 0, 1, 0, 32'h0000_0400, 4'b0000, 32'h0,        32'h0,        32'h0000_00F1, 32'h0000_0000};
        vecs[6]  = '{1, 3'b010, 0, 32'h0000_0502, 32'h0,        1, 3'b000, 0, 32'h0000_0000, 32'h0,        32'h8001_7777, 32'h0,        0, 0, 1, 0, 32'h0000_0500, 4'b0000, 32'h0,        32'h0,        32'hFFFF_8001, 32'h0000_0000};
        vecs[7]  = '{1, 3'b010, 0, 32'h0000_0601, 32'h0,        1, 3'b011, 0, 32'h0000_0700, 32'h0,        32'h0,        32'h0,        1, 0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        32'h0000_0601, 32'h0000_0700};
        vecs[8]  = '{1, 3'b000, 0, 32'h0000_0011, 32'h0,        1, 3'b011, 0, 32'h0000_0702, 32'h0,        32'h0,        32'h0,        0, 1, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        32'h0000_0011, 32'h0000_0702};
        vecs[9]  = '{1, 3'b111, 1, 32'h0000_0033, 32'h0,        1, 3'b100, 1, 32'h0000_0044, 32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        32'h0000_0033, 32'h0000_0044};
        vecs[10] = '{0, 3'b011, 0, 32'h0000_0800, 32'h0,        0, 3'b010, 0, 32'h0000_0901, 32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        32'h0000_0800, 32'h0000_0901};
        vecs[11] = '{1, 3'b011, 1, 32'h0000_0900, 32'hDEAD_BEEF, 1, 3'b001, 0, 32'h0000_0903, 32'h0,        32'h0,        32'h7F00_0000, 0, 0, 2, 1, 32'h0000_0900, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0900, 32'h0000_0900, 32'h0000_007F};
        vecs[12] = '{1, 3'b010, 1, 32'h0000_2000, 32'h0000_CAFE, 1, 3'b010, 0, 32'h0000_2002, 32'h0,        32'h0,        32'h7FFF_0000, 0, 0, 2, 1, 32'h0000_2000, 4'b0011, 32'hCAFE_CAFE, 32'h0000_2000, 32'h0000_2000, 32'h0000_7FFF};

        // Reset with a store presented: nothing may leak onto the request bus.
        rstn           = 1'b0;
        bus.dc_addr_ok = 1'b0;
        bus.dc_data_ok = 1'b0;
        bus.dc_rdata   = 32'd0;
        setSlots(1, 3'b011, 1, 32'h0000_0040, 32'hFFFF_FFFF, 0, 3'b000, 0, 32'h0, 32'h0);
        tick();
        tick();
        checkOutput("rst_req", {31'd0, bus.dc_req}, 32'd0);
        checkOutput("rst_we", {31'd0, bus.dc_we}, 32'd0);
        checkOutput("rst_addr", bus.dc_addr, 32'd0);
        checkOutput("rst_wstrb", {28'd0, bus.dc_wstrb}, 32'd0);
        checkOutput("rst_wdata", bus.dc_wdata, 32'd0);
        checkOutput("rst_rfA", bus.MEM_rf_wdata_a, 32'h0000_0040);
        setSlots(0, 3'b000, 0, 32'h0, 32'h0, 0, 3'b000, 0, 32'h0, 32'h0);
        rstn = 1'b1;
        tick();
        checkOutput("rst_stall", {31'd0, bus.stall_dcache}, 32'd0);

        for (int i = 0; i < NUM_VEC; i++) begin
            applyStimulus(i, vecs[i]);
        end

        // addr_ok withheld: the request must hold steady and the stall persist.
        setSlots(1, 3'b011, 0, 32'h0000_0A00, 32'h0, 1, 3'b000, 0, 32'h0, 32'h0);
        tick();
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("hold%0d_req", k), {31'd0, bus.dc_req}, 32'd1);
            checkOutput($sformatf("hold%0d_addr", k), bus.dc_addr, 32'h0000_0A00);
            checkOutput($sformatf("hold%0d_stall", k), {31'd0, bus.stall_dcache}, 32'd1);
            if (k < 3) tick();
        end
        bus.dc_addr_ok = 1'b1;
        tick();
        bus.dc_addr_ok = 1'b0;
        bus.dc_data_ok = 1'b1;
        bus.dc_rdata   = 32'hCAFE_F00D;
        tick();
        bus.dc_data_ok = 1'b0;
        checkOutput("hold_stallEnd", {31'd0, bus.stall_dcache}, 32'd0);
        checkOutput("hold_rfA", bus.MEM_rf_wdata_a, 32'hCAFE_F00D);
        tick();

        // Reset while in WAIT, then a stale data_ok that must be ignored.
        setSlots(1, 3'b011, 0, 32'h0000_0B00, 32'h0, 1, 3'b000, 0, 32'h0, 32'h0);
        tick();
        bus.dc_addr_ok = 1'b1;
        tick();
        bus.dc_addr_ok = 1'b0;
        checkOutput("rw_waitReq", {31'd0, bus.dc_req}, 32'd0);
        rstn = 1'b0;
        tick();
        checkOutput("rw_rstReq", {31'd0, bus.dc_req}, 32'd0);
        checkOutput("rw_rstStall", {31'd0, bus.stall_dcache}, 32'd1);
        rstn           = 1'b1;
        bus.dc_data_ok = 1'b1;
        bus.dc_rdata   = 32'h1234_5678;
        tick();
        bus.dc_data_ok = 1'b0;
        checkOutput("rw_lateRfA", bus.MEM_rf_wdata_a, 32'h0000_0B00);
        checkOutput("rw_lateStall", {31'd0, bus.stall_dcache}, 32'd1);
        checkOutput("rw_reissue", {31'd0, bus.dc_req}, 32'd1);
        bus.dc_addr_ok = 1'b1;
        tick();
        bus.dc_addr_ok = 1'b0;
        bus.dc_data_ok = 1'b1;
        bus.dc_rdata   = 32'h0BAD_F00D;
        tick();
        bus.dc_data_ok = 1'b0;
        checkOutput("rw_stallEnd", {31'd0, bus.stall_dcache}, 32'd0);
        checkOutput("rw_rfA", bus.MEM_rf_wdata_a, 32'h0BAD_F00D);
        tick();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rstn  in  1  reset, synchronous, active-low.
REQ-004 MEM_valid_a / MEM_valid_b  in  1 each  slot holds a live (non-flushed) instruction.
REQ-005 MEM_mem_type_a / MEM_mem_type_b  in  3 each  000 none, 001 B, 010 H, 011 W, 101 BU, 110 HU; others = none.
REQ-006 MEM_mem_we_a / MEM_mem_we_b  in  1 each  1 = store, 0 = load; ignored when type is none.
REQ-007 MEM_alu_result_a / MEM_alu_result_b  in  32 each  ALU result; byte address for memory ops.
REQ-008 MEM_store_data_a / MEM_store_data_b  in  32 each  store source register value.
REQ-009 stall_dcache  out  1  holds the EX->MEM pipeline register while any memory op is outstanding.
REQ-010 MEM_rf_wdata_a / MEM_rf_wdata_b  out  32 each  writeback data to the MEM->WB register.
REQ-011 mem_ale_a / mem_ale_b  out  1 each  misaligned-address flag, combinational.
REQ-012 dc_req  out 1; dc_we  out 1; dc_addr  out 32; dc_wstrb  out 4; dc_wdata  out 32: dcache request.
REQ-013 dc_addr_ok  in 1 request accepted; dc_data_ok  in 1 access complete; dc_rdata  in 32 load word.

Function
REQ-014 is_mem_x SHALL = MEM_valid_x & (type_x in {B,H,W,BU,HU}).
REQ-015 mem_ale_x SHALL be 1 when is_mem_x & ((H/HU & addr[0]) | (W & addr[1:0]!=0)).
REQ-016 mem_ale_a SHALL suppress slot B's memory op; a misaligned slot never issues a request.
REQ-017 pend_x SHALL = is_mem_x & !ale-suppressed & !done_x; stall_dcache SHALL = pend_a | pend_b (combinational).
REQ-018 done_a, done_b SHALL be registers, set on dc_data_ok for the current slot, cleared on any edge with stall_dcache = 0.
REQ-019 FSM states IDLE, REQ, WAIT; cur register selects slot (0 = A, 1 = B).
REQ-020 IDLE: pend_a -> REQ, cur=A; else pend_b -> REQ, cur=B; else stay.
REQ-021 REQ: dc_req=1; dc_addr_ok=1 -> WAIT; else hold REQ with all request outputs stable.
REQ-022 WAIT: dc_data_ok=1 -> set done_cur; if cur=A and pend_b -> REQ, cur=B; else IDLE.
REQ-023 dc_data_ok in IDLE or REQ SHALL be ignored; dc_data_ok never arrives in the same cycle as its dc_addr_ok.
REQ-024 dc_addr = {addr[31:2], 2'b00}; dc_we = MEM_mem_we_cur; request outputs are 0 outside REQ.
REQ-025 Store wstrb: B 0001<<addr[1:0]; H 0011<<addr[1:0]; W 1111; loads 0000.
REQ-026 Store wdata: B data[7:0] replicated x4; H data[15:0] replicated x2; W data.
REQ-027 Load: dc_rdata >> (8*addr[1:0]); B/H sign-extend, BU/HU zero-extend, W unchanged; result captured into load_data_cur on dc_data_ok.
REQ-028 MEM_rf_wdata_x SHALL = load_data_x for a completed load, else MEM_alu_result_x.
REQ-029 Latency: a load with dc_addr_ok in its REQ cycle stalls 2 cycles after entering MEM; one idle cycle precedes REQ; the dual-op pair is serialised A then B.
REQ-030 Stores SHALL wait for dc_data_ok before their done flag sets.

Reset
REQ-031 rstn=0 at an edge: FSM=IDLE, cur=A, done_a=done_b=0, load_data_a=load_data_b=0; dc_req=0; dc_we=0; dc_addr, dc_wstrb, dc_wdata = 0.
REQ-032 Reset mid-access abandons the access; a late dc_data_ok arriving after reset SHALL be ignored (IDLE rule).

Verification
REQ-033 A: LD.B, addr 0x1003; dc_rdata 0x80_00_00_00 -> dc_wstrb 0000, MEM_rf_wdata_a 0xFFFFFF80; stall drops the cycle after data_ok.
REQ-034 B: ST.H, addr 0x2002, data 0x1234ABCD -> dc_wstrb 1100, dc_wdata 0xABCDABCD, dc_we 1.
REQ-035 A LD.W 0x100 and B LD.HU 0x106, rdata 0x11223344 then 0xBEEF0000 -> requests A then B; rf_wdata_a 0x11223344, rf_wdata_b 0x0000BEEF.
REQ-036 A LD.W addr 0x101 -> mem_ale_a 1, no dc_req, stall_dcache 0; B's memory op suppressed.
REQ-037 dc_addr_ok held 0 for 3 cycles -> dc_req and dc_addr stable throughout; stall held.
REQ-038 rstn low during WAIT, then dc_data_ok -> FSM IDLE, done flags 0, no rf_wdata update.
